// File: rtl/scroll_pkg.sv
// Shared types and constants for the scrolling display sequencer.
// Holds the state encoding, 7-segment codes (active-low, bit0 = segment a) and the message ROM.
package scroll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SCROLL = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [6:0] HEX_OFF = 7'h7F;
    localparam logic [6:0] CH_H    = 7'h09;
    localparam logic [6:0] CH_E    = 7'h06;
    localparam logic [6:0] CH_L    = 7'h47;
    localparam logic [6:0] CH_O    = 7'h40;
    localparam logic [6:0] CH_D    = 7'h21;
    localparam logic [6:0] CH_1    = 7'h79;

    localparam int MSG_ROM_LEN = 16;

    // "HELLO dE1", padded with blanks
    localparam logic [6:0] MSG_ROM [MSG_ROM_LEN] = '{
        CH_H, CH_E, CH_L, CH_L, CH_O, HEX_OFF, CH_D, CH_E,
        CH_1, HEX_OFF, HEX_OFF, HEX_OFF, HEX_OFF, HEX_OFF, HEX_OFF, HEX_OFF
    };

    function automatic logic [6:0] msg_char(input logic [7:0] idx);
        if (idx < 8'(MSG_ROM_LEN)) begin
            return MSG_ROM[idx[3:0]];
        end
        return HEX_OFF;
    endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll time base: prescaler producing base_tick, and a speed divider producing step.
// With SCROLL_BLINK_EN defined, freeze stops only the step divider while the prescaler runs.
module scroll_tick_gen
    import scroll_pkg::*;
#(
    parameter  int TICK_DIV = 25_000_000,
    localparam int PRE_W    = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
`ifdef SCROLL_BLINK_EN
    input  logic       freeze,
`endif
    input  logic [1:0] speed,
    output logic       base_tick,
    output logic       step
);

    logic [PRE_W-1:0] pre_cnt;
    logic [2:0]       sub_cnt;
    logic [2:0]       sub_lim;
    logic             sub_en;

`ifdef SCROLL_BLINK_EN
    assign sub_en = en && !freeze;
`else
    assign sub_en = en;
`endif

    always_comb begin
        sub_lim = 3'd0;
        case (speed)
            2'd0:    sub_lim = 3'd0;
            2'd1:    sub_lim = 3'd1;
            2'd2:    sub_lim = 3'd3;
            default: sub_lim = 3'd7;
        endcase
    end

    assign base_tick = en && (pre_cnt == PRE_W'(TICK_DIV - 1));
    // >= rather than == so a speed decrease below the current count fires on the next tick
    assign step      = base_tick && sub_en && (sub_cnt >= sub_lim);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            sub_cnt <= '0;
        end else begin
            if (base_tick) begin
                pre_cnt <= '0;
            end else if (en) begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
            if (step) begin
                sub_cnt <= '0;
            end else if (base_tick && sub_en) begin
                sub_cnt <= sub_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/scroll_controller.sv
// Scrolling display sequencer: window pointer, six 7-segment codes with load pulses, wrap pulse.
// Define SCROLL_BLINK_EN to blink the display (window / all off) on each base tick while paused.
//   state  | meaning
//   IDLE   | outputs at reset values, waiting for run
//   LOAD   | first window (ptr 0) just loaded and pulsed
//   SCROLL | stepping the pointer on each step
//   HOLD   | paused, counters and display frozen
module scroll_controller
    import scroll_pkg::*;
#(
    parameter  int TICK_DIV = 25_000_000,
    parameter  int MSG_LEN  = 16,
    localparam int PW       = $clog2(MSG_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          dir,
    input  logic [1:0]    speed,
    output logic [41:0]   hex_out,
    output logic [5:0]    hex_en,
    output logic          ledr_en,
    output logic [PW-1:0] ptr
);

    state_t         state, next_state;
    logic           tick_en, step;
    logic [PW-1:0]  ptr_step, ptr_d;
    logic           wrap;
    logic [41:0]    win_cur, win_step, hex_out_d;
    logic [5:0]     hex_en_d;
    logic           ledr_en_d;

    function automatic logic [41:0] window(input logic [PW-1:0] p);
        logic [PW:0] idx;
        window = '0;
        for (int k = 0; k < 6; k++) begin
            idx = {1'b0, p} + (PW+1)'(5 - k);
            if (idx >= (PW+1)'(MSG_LEN)) begin
                idx = idx - (PW+1)'(MSG_LEN);
            end
            window[7*k +: 7] = msg_char(8'(idx));
        end
    endfunction

`ifdef SCROLL_BLINK_EN
    logic base_tick, blank, blank_d;
    assign tick_en = (state == SCROLL) || (state == HOLD);

    scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .en        (tick_en),
        .freeze    (state == HOLD),
        .speed     (speed),
        .base_tick (base_tick),
        .step      (step)
    );
`else
    assign tick_en = (state == SCROLL);

    scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .en        (tick_en),
        .speed     (speed),
        .base_tick (),
        .step      (step)
    );
`endif

    always_comb begin
        if (dir) begin
            wrap     = (ptr == '0);
            ptr_step = wrap ? PW'(MSG_LEN - 1) : ptr - PW'(1);
        end else begin
            wrap     = (ptr == PW'(MSG_LEN - 1));
            ptr_step = wrap ? '0 : ptr + PW'(1);
        end
    end

    assign win_cur  = window(ptr);
    assign win_step = window(ptr_step);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (run)  next_state = LOAD;
            LOAD:              next_state = SCROLL;
            SCROLL:  if (!run) next_state = HOLD;
            HOLD:    if (run)  next_state = SCROLL;
            default:           next_state = IDLE;
        endcase
    end

    // Outputs are registered on the edge that enters the reported cycle, so LOAD pulses in LOAD itself.
    always_comb begin
        ptr_d     = ptr;
        hex_out_d = hex_out;
        hex_en_d  = '0;
        ledr_en_d = 1'b0;
`ifdef SCROLL_BLINK_EN
        blank_d   = blank;
`endif
        case (state)
            IDLE: begin
                if (run) begin
                    hex_out_d = win_cur;
                    hex_en_d  = '1;
                end
            end
            SCROLL: begin
                if (step) begin
                    ptr_d     = ptr_step;
                    hex_out_d = win_step;
                    hex_en_d  = '1;
                    ledr_en_d = wrap;
                end
            end
`ifdef SCROLL_BLINK_EN
            HOLD: begin
                if (run) begin
                    hex_out_d = win_cur;
                    hex_en_d  = '1;
                    blank_d   = 1'b0;
                end else if (base_tick) begin
                    hex_out_d = blank ? win_cur : {6{HEX_OFF}};
                    hex_en_d  = '1;
                    blank_d   = !blank;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            hex_out <= {6{HEX_OFF}};
            hex_en  <= '0;
            ledr_en <= 1'b0;
        end else begin
            ptr     <= ptr_d;
            hex_out <= hex_out_d;
            hex_en  <= hex_en_d;
            ledr_en <= ledr_en_d;
        end
    end

`ifdef SCROLL_BLINK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            blank <= 1'b0;
        end else begin
            blank <= blank_d;
        end
    end
`endif

endmodule

// File: tb/tb_scroll_controller.sv
// Scoreboard bench for scroll_controller: a cycle-level reference model queues expected pulses,
// a negedge monitor pops and compares whenever the DUT presents hex_en or ledr_en.
module tb_scroll_controller;

    localparam int TD = 4;
    localparam int ML = 8;
    localparam int PW = $clog2(ML);

    localparam logic [6:0] MSG [16] = '{
        7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F, 7'h21, 7'h06,
        7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    logic          clk = 1'b0;
    logic          reset, run, dir;
    logic [1:0]    speed;
    logic [41:0]   hex_out;
    logic [5:0]    hex_en;
    logic          ledr_en;
    logic [PW-1:0] ptr;

    scroll_controller #(.TICK_DIV(TD), .MSG_LEN(ML)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .dir     (dir),
        .speed   (speed),
        .hex_out (hex_out),
        .hex_en  (hex_en),
        .ledr_en (ledr_en),
        .ptr     (ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          p;
        logic [41:0] hex;
        bit          ledr;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // reference model: mode 0 idle, 1 load, 2 scroll, 3 hold
    int mode = 0, mptr = 0, pre = 0, ticks = 0;
    bit blank = 0;

    function automatic logic [41:0] win(input int p);
        logic [41:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r[7*k +: 7] = MSG[(p + 5 - k) % ML];
        return r;
    endfunction

    function automatic void push(input int p, input logic [41:0] h, input bit l);
        exp_t e;
        e.cyc = cyc; e.p = p; e.hex = h; e.ledr = l;
        expq.push_back(e);
    endfunction

    function automatic bit will_step();
        return (mode == 2) && (pre == TD - 1) && (ticks + 1 >= (1 << speed));
    endfunction

    function automatic void model_edge();
        bit tick, wrapped;
        if (reset) begin
            mode = 0; mptr = 0; pre = 0; ticks = 0; blank = 0;
            return;
        end
        case (mode)
            0: if (run) begin mode = 1; push(0, win(0), 1'b0); end
            1: mode = 2;
            2: begin
                tick = (pre == TD - 1);
                pre  = (pre + 1) % TD;
                if (tick) begin
                    ticks++;
                    if (ticks >= (1 << speed)) begin
                        ticks   = 0;
                        wrapped = dir ? (mptr == 0) : (mptr == ML - 1);
                        mptr    = dir ? (mptr + ML - 1) % ML : (mptr + 1) % ML;
                        push(mptr, win(mptr), wrapped);
                    end
                end
                if (!run) mode = 3;
            end
            default: begin
`ifdef SCROLL_BLINK_EN
                tick = (pre == TD - 1);
                pre  = (pre + 1) % TD;
                if (run) begin
                    blank = 0;
                    push(mptr, win(mptr), 1'b0);
                end else if (tick) begin
                    blank = !blank;
                    push(mptr, blank ? {6{7'h7F}} : win(mptr), 1'b0);
                end
`endif
                if (run) mode = 2;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic cycle_once();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle_once();
    endtask

    // advance until the next edge is a step (optionally from a given pointer)
    task automatic wait_step(input int want_ptr, input int budget);
        int n = 0;
        while (!(will_step() && (want_ptr < 0 || mptr == want_ptr)) && n < budget) begin
            cycle_once();
            n++;
        end
        if (!(will_step() && (want_ptr < 0 || mptr == want_ptr))) begin
            checks++;
            errors++;
            $display("FAIL wait_step: no step from ptr %0d within %0d cycles", want_ptr, budget);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_hex_out", 64'(hex_out), 64'(42'h3FF_FFFF_FFFF));
        check("rst_hex_en",  64'(hex_en), 64'(0));
        check("rst_ledr_en", 64'(ledr_en), 64'(0));
        check("rst_ptr",     64'(ptr), 64'(0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (hex_en != 6'd0 || ledr_en) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: hex_en %0h ledr_en %0b ptr %0d, expected none",
                         cyc, hex_en, ledr_en, ptr);
            end else begin
                e = expq.pop_front();
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("hex_en",      64'(hex_en), 64'(6'h3F));
                check("ptr",         64'(ptr), 64'(e.p));
                check("hex_out",     64'(hex_out), 64'(e.hex));
                check("ledr_en",     64'(ledr_en), 64'(e.ledr));
            end
        end
    end

    initial begin
        int r;
        reset = 1'b1; run = 1'b1; dir = 1'b0; speed = 2'd0;
        cycles(3);
        check_reset_outputs();
        reset = 1'b0;

        // full left pass through the wrap
        cycles(40);

        // reverse at ptr 0: wraps to 7 with ledr, then 6 without
        wait_step(0, 200);
        dir = 1'b1;
        cycle_once();
        cycles(8);

        // slow speed, then drop to speed 0 with two ticks already counted
        dir = 1'b0; speed = 2'd2;
        cycles(40);
        wait_step(-1, 200);
        cycle_once();
        cycles(2 * TD);
        speed = 2'd0;
        cycles(2 * TD);

        // pause on the step cycle, stay paused, resume
        wait_step(-1, 200);
        run = 1'b0;
        cycle_once();
        cycles(20);
        run = 1'b1;
        cycles(30);

        // randomized switches with occasional reset
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4)       run   = ~run;
            else if (r < 8)  dir   = ~dir;
            else if (r < 12) speed = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 199) == 0);
            cycle_once();
        end
        reset = 1'b0;

        // reset while scrolling at ptr 5
        run = 1'b1; dir = 1'b0; speed = 2'd0;
        wait_step(5, 300);
        reset = 1'b1;
        cycle_once();
        check_reset_outputs();
        reset = 1'b0; run = 1'b0;
        cycles(10);
        check("queue_empty", 64'(expq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
